counter_sched: RTL and testbench
================================

COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters sharing the interval counter (2..8).
REQ-002 Parameter: CW, default 6, counter width in bits.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req  input  NREQ  per-requester request; held high until that requester's done pulse.
REQ-006 Port: req_tc  input  NREQ*CW  per-requester terminal count; slice i is bits [i*CW +: CW].
REQ-007 Port: abort  input  1  cancels the interval currently owned; ignored outside COUNT.
REQ-008 Port: grant  output  NREQ  one-hot owner of the counter, registered.
REQ-009 Port: busy  output  1  high whenever state is not IDLE, registered.
REQ-010 Port: count  output  CW  current counter value, registered.
REQ-011 Port: done  output  NREQ  one-cycle, one-hot completion pulse to the owner, registered.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, GRANT, COUNT and DONE.
REQ-013 IDLE: when any req bit is high, the block SHALL select a winner by round-robin and go to GRANT; otherwise it SHALL stay in IDLE.
REQ-014 Round-robin: priority starts at the pointer index and ascends modulo NREQ; after each DONE or abort, the pointer SHALL move to winner+1 mod NREQ.
REQ-015 GRANT: the block SHALL assert grant[winner], latch the winner's req_tc into tc_l, set count to 0 and go to COUNT.
REQ-016 COUNT, count==tc_l: the block SHALL go to DONE with count held.
REQ-017 COUNT, count!=tc_l: count SHALL increment by 1 with no wrap, since count never exceeds tc_l <= 2^CW-1.
REQ-018 COUNT, abort high: abort SHALL take precedence over REQ-016 and REQ-017; the next state SHALL be IDLE with grant=0, count=0 and no done pulse.
REQ-019 DONE: done[winner] SHALL be high for exactly this cycle with grant still held; the next state SHALL be IDLE with grant=0.
REQ-020 Latency: if req is sampled in IDLE at cycle n, grant is visible at n+1, COUNT lasts tc+1 cycles, and done pulses at n+tc+3.
REQ-021 tc=0: COUNT SHALL last one cycle and done SHALL pulse at n+3.
REQ-022 Changes on req or req_tc after GRANT SHALL be ignored until the next IDLE.
REQ-023 A requester still requesting in the IDLE after its DONE SHALL be eligible, but at lowest priority.
REQ-024 Simultaneous requests SHALL yield exactly one grant; grant SHALL never have more than one bit high.
REQ-025 Back-to-back operation: minimum gap from done to the next grant SHALL be one IDLE cycle.

Reset
REQ-026 When reset is high, the next state SHALL be IDLE, with grant=0, done=0, busy=0, count=0, tc_l=0 and the round-robin pointer at 0.
REQ-027 Reset SHALL override abort and all transitions, including in the middle of COUNT.
REQ-028 Requests pending at reset release SHALL be arbitrated from pointer 0 in the first IDLE cycle.

Structure
REQ-029 The state enumeration and the default CW/NREQ constants SHALL live in the shared package counter_sched_pkg.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req and pointer; output one-hot winner), purely combinational, instanced once.

Verification
REQ-031 Single request: req=0001, tc=3, sampled at cycle n -> grant=0001 at n+1, count sequence 0,0,1,2,3, done=0001 at n+6, busy low at n+7.
REQ-032 Contention: req=1111 with all tc=1 held -> grant order 0001, 0010, 0100, 1000, 0001, each with one done pulse.
REQ-033 tc=0 and full scale: tc=0 -> done at n+3; tc=63 -> count reaches 63 without wrap, done at n+66.
REQ-034 Abort: tc=10, abort at count=4 -> next cycle grant=0, count=0, busy=0, no done, and the pointer advances.
REQ-035 Mid-operation reset: reset at count=5 -> next cycle all outputs 0; with req=0110 held, grant=0010 appears one cycle after reset release.
REQ-036 Assertions: grant is one-hot or zero; done is a subset of grant; done is never high for two consecutive cycles.

Source files
------------

// File: rtl/counter_sched_pkg.sv
// Shared types and defaults for the counter scheduler: FSM state encoding,
// default sizing and a small modulo helper for the round-robin pointer.
package counter_sched_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_CW   = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int inc_mod(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin picker: scans upward from ptr_i (mod NREQ) and
// returns the first requester found as a one-hot vector.
module rr_arbiter
  import counter_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o
);

  logic [PW:0] idx_w;
  logic        found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx_w = '0;
    for (int k = 0; k < NREQ; k++) begin
      // one extra bit so ptr+k can be folded back below NREQ
      idx_w = {1'b0, ptr_i} + (PW+1)'(k);
      if (idx_w >= (PW+1)'(NREQ)) begin
        idx_w = idx_w - (PW+1)'(NREQ);
      end
      if (!found && req_i[idx_w[PW-1:0]]) begin
        gnt_o[idx_w[PW-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Shared interval counter: requesters are granted round-robin, the owner's
// terminal count is latched and counted up to, then a one-cycle done is issued.
//
// state    | meaning
// ST_IDLE  | no owner; arbitrate pending requests
// ST_GRANT | owner granted; latch its terminal count, clear counter
// ST_COUNT | counting up to the latched terminal count; abort cancels
// ST_DONE  | done pulse to owner, grant still held
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int CW   = DEF_CW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] req_tc,
  input  logic               abort,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic [CW-1:0]      count,
  output logic [NREQ-1:0]    done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   tc_l_q, tc_l_d;
  logic [CW-1:0]   count_q, count_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] win_oh;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   ptr_next;
  logic [CW-1:0]   tc_sel;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (win_oh)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) begin
        win_idx = PW'(i);
      end
    end
  end

  always_comb begin
    tc_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == PW'(i)) begin
        tc_sel = req_tc[i*CW +: CW];
      end
    end
  end

  assign ptr_next = PW'(inc_mod(int'(owner_q), NREQ));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    tc_l_d  = tc_l_q;
    count_d = count_q;
    grant_d = grant_q;
    done_d  = '0;

    unique case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        count_d = '0;
        if (|req) begin
          state_d = ST_GRANT;
          owner_d = win_idx;
          grant_d = win_oh;
        end
      end
      ST_GRANT: begin
        tc_l_d  = tc_sel;
        count_d = '0;
        state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (abort) begin
          state_d = ST_IDLE;
          grant_d = '0;
          count_d = '0;
          ptr_d   = ptr_next;
        end else if (count_q == tc_l_q) begin
          state_d = ST_DONE;
          done_d  = grant_q;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        count_d = '0;
        ptr_d   = ptr_next;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      tc_l_q  <= '0;
      count_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      tc_l_q  <= tc_l_d;
      count_q <= count_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched: expected grants are queued as requests are
// driven and checked (owner, latency, final count) by a negedge monitor.
module tb_counter_sched;

  localparam int NREQ = 4;
  localparam int CW   = 6;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] req_tc;
  logic               abort;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic [CW-1:0]      count;
  logic [NREQ-1:0]    done;

  always #5 clk = ~clk;

  counter_sched #(.NREQ(NREQ), .CW(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .req_tc (req_tc),
    .abort  (abort),
    .grant  (grant),
    .busy   (busy),
    .count  (count),
    .done   (done)
  );

  typedef struct {
    logic [NREQ-1:0] gnt;
    int              tc;
    bit              no_done;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;
  int   cyc;
  bit   mon_en;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_tc(input int i, input int v);
    req_tc[i*CW +: CW] = CW'(v);
  endtask

  task automatic push(input logic [NREQ-1:0] g, input int tc, input bit nd);
    exp_t e;
    e.gnt = g;
    e.tc = tc;
    e.no_done = nd;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int limit, output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (done == '0 && k < limit);
    if (done == '0) check("done_timeout", 32'(done != '0), 1);
  endtask

  // scoreboard monitor and protocol invariants
  logic [NREQ-1:0] grant_p = '0;
  logic [NREQ-1:0] done_p = '0;
  exp_t cur;
  bit   have_cur;
  bit   done_seen;
  int   t_grant;

  always @(negedge clk) begin
    if (mon_en) begin
      check("grant_onehot0", 32'($onehot0(grant)), 1);
      check("done_in_grant", 32'((done & ~grant) == '0), 1);
      check("done_consecutive", 32'((|done) & (|done_p)), 0);
      if (grant != '0 && grant_p == '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(grant), 0);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          done_seen = 1'b0;
          t_grant = cyc;
          check("grant_owner", 32'(grant), 32'(cur.gnt));
        end
      end
      if (done != '0) begin
        if (!have_cur || cur.no_done) begin
          check("unexpected_done", 32'(done), 0);
        end else begin
          done_seen = 1'b1;
          check("done_owner", 32'(done), 32'(cur.gnt));
          check("done_latency", 32'(cyc - t_grant), 32'(cur.tc + 2));
          check("done_count", 32'(count), 32'(cur.tc));
        end
      end
      if (grant == '0 && grant_p != '0) begin
        if (have_cur && !cur.no_done) check("missing_done", 32'(done_seen), 1);
        have_cur = 1'b0;
      end
    end
    grant_p = grant;
    done_p = done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int k2;
    int exp_cnt[6] = '{0, 0, 1, 2, 3, 3};

    reset = 1'b1;
    req = '0;
    req_tc = '0;
    abort = 1'b0;
    repeat (3) step();
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(count), 0);
    check("rst_done", 32'(done), 0);
    reset = 1'b0;
    mon_en = 1'b1;
    step();

    // single request, tc=3
    req = 4'b0001;
    set_tc(0, 3);
    push(4'b0001, 3, 1'b0);
    for (int j = 1; j <= 7; j++) begin
      step();
      if (j <= 6) begin
        check("t1_count", 32'(count), 32'(exp_cnt[j-1]));
        check("t1_grant", 32'(grant), 32'(4'b0001));
      end else begin
        check("t1_grant_clr", 32'(grant), 0);
      end
      check("t1_done", 32'(done), (j == 6) ? 32'(4'b0001) : 32'(0));
      check("t1_busy", 32'(busy), 32'(j <= 6));
      if (j == 6) req = '0;
    end

    // tc=0 on requester 2 (pointer now 1)
    req = 4'b0100;
    set_tc(2, 0);
    push(4'b0100, 0, 1'b0);
    wait_done(20, k);
    check("tc0_latency", 32'(k), 3);
    req = '0;
    step();

    // full scale on requester 3; tc change after grant must be ignored
    req = 4'b1000;
    set_tc(3, 63);
    push(4'b1000, 63, 1'b0);
    step();
    step();
    set_tc(3, 5);
    wait_done(100, k2);
    check("tc63_latency", 32'(k2 + 2), 66);
    check("tc63_count", 32'(count), 63);
    req = '0;
    step();

    // abort at count=4 (pointer now 0)
    req = 4'b0001;
    set_tc(0, 10);
    push(4'b0001, 10, 1'b1);
    k = 0;
    do begin
      step();
      k++;
    end while (!(busy && count == CW'(4) && k > 2) && k < 30);
    check("abort_reach4", 32'(count), 4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_grant", 32'(grant), 0);
    check("abort_count", 32'(count), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    // pointer must have moved past requester 0
    req = 4'b0011;
    set_tc(1, 2);
    push(4'b0010, 2, 1'b0);
    wait_done(20, k);
    check("after_abort_latency", 32'(k), 5);
    req = '0;
    step();

    // reset in the middle of COUNT, also overriding abort (pointer now 2)
    req = 4'b0100;
    set_tc(2, 20);
    push(4'b0100, 20, 1'b1);
    k = 0;
    do begin
      step();
      k++;
    end while (!(busy && count == CW'(5)) && k < 30);
    check("rst_mid_reach5", 32'(count), 5);
    reset = 1'b1;
    abort = 1'b1;
    req = 4'b0110;
    step();
    abort = 1'b0;
    check("rst_mid_grant", 32'(grant), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_count", 32'(count), 0);
    check("rst_mid_done", 32'(done), 0);
    reset = 1'b0;
    set_tc(1, 1);
    push(4'b0010, 1, 1'b0);
    step();
    check("rst_rel_grant", 32'(grant), 32'(4'b0010));
    wait_done(20, k);
    req = '0;
    step();

    // contention from pointer 0, all tc=1
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_tc(i, 1);
    req = 4'b1111;
    push(4'b0001, 1, 1'b0);
    push(4'b0010, 1, 1'b0);
    push(4'b0100, 1, 1'b0);
    push(4'b1000, 1, 1'b0);
    push(4'b0001, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      wait_done(20, k);
      if (i == 4) begin
        req = '0;
      end else begin
        step();
        check("gap_idle", 32'(grant), 0);
        step();
        check("gap_regrant", 32'(grant != '0), 1);
      end
    end
    step();
    step();
    check("final_busy", 32'(busy), 0);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
